// File: rtl/floo_vc_credit_scheduler.sv
// Credit-based virtual-channel scheduler: several VC flit streams share one
// physical link, gated by per-VC downstream credits and optional wormhole locking.
module floo_vc_credit_scheduler #(
  parameter int unsigned NumVirtChannels = 2,
  parameter int unsigned CreditDepth     = 4,
  parameter bit          WormholeLock    = 1'b1,
  parameter type         flit_t          = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumVirtChannels-1:0] valid_i,
  output logic [NumVirtChannels-1:0] ready_o,
  input  flit_t                      data_i [NumVirtChannels],
  input  logic [NumVirtChannels-1:0] last_i,
  output logic                       valid_o,
  output flit_t                      data_o,
  output logic [((NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1)-1:0] vc_id_o,
  input  logic [NumVirtChannels-1:0] credit_i,
  output logic                       credit_overflow_o
);

  localparam int unsigned VcW  = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1;
  localparam int unsigned CntW = $clog2(CreditDepth + 1);
  localparam logic [VcW-1:0]  LastVc  = VcW'(NumVirtChannels - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(CreditDepth);
  localparam logic [VcW:0]    NumVcs  = (VcW + 1)'(NumVirtChannels);

  if (NumVirtChannels < 1) begin : g_bad_num_vcs
    $fatal(1, "floo_vc_credit_scheduler: NumVirtChannels must be at least 1");
  end
  if (CreditDepth < 1) begin : g_bad_credit_depth
    $fatal(1, "floo_vc_credit_scheduler: CreditDepth must be at least 1");
  end

  logic [CntW-1:0]            cnt [NumVirtChannels];
  logic [VcW-1:0]             rr_ptr;
  logic                       lock;
  logic [VcW-1:0]             lock_vc;
  logic [NumVirtChannels-1:0] eligible;
  logic                       grant_valid;
  logic [VcW-1:0]             grant_idx;

  always_comb begin
    eligible = '0;
    for (int v = 0; v < NumVirtChannels; v++) begin
      eligible[v] = valid_i[v] && (cnt[v] != '0);
    end
  end

  // Round-robin search from rr_ptr; iterating downward lets the closest candidate win.
  always_comb begin
    logic [VcW:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    if (lock) begin
      if (eligible[lock_vc]) begin
        grant_valid = 1'b1;
        grant_idx   = lock_vc;
      end
    end else begin
      for (int i = NumVirtChannels - 1; i >= 0; i--) begin
        cand = {1'b0, rr_ptr} + (VcW + 1)'(i);
        if (cand >= NumVcs) begin
          cand = cand - NumVcs;
        end
        if (eligible[cand[VcW-1:0]]) begin
          grant_valid = 1'b1;
          grant_idx   = cand[VcW-1:0];
        end
      end
    end
  end

  always_comb begin
    ready_o = '0;
    valid_o = 1'b0;
    data_o  = data_i[grant_idx];
    vc_id_o = grant_idx;
    if (!rst_i && grant_valid) begin
      valid_o            = 1'b1;
      ready_o[grant_idx] = 1'b1;
    end
  end

  // ready_o is exactly the one-hot fire vector, so it doubles as the credit decrement.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int v = 0; v < NumVirtChannels; v++) begin
        cnt[v] <= FullCnt;
      end
      credit_overflow_o <= 1'b0;
    end else begin
      for (int v = 0; v < NumVirtChannels; v++) begin
        case ({ready_o[v], credit_i[v]})
          2'b10:   cnt[v] <= cnt[v] - CntW'(1);
          2'b01: begin
            if (cnt[v] == FullCnt) begin
              credit_overflow_o <= 1'b1;
            end else begin
              cnt[v] <= cnt[v] + CntW'(1);
            end
          end
          default: cnt[v] <= cnt[v];
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr  <= '0;
      lock    <= 1'b0;
      lock_vc <= '0;
    end else if (valid_o) begin
      if (WormholeLock) begin
        lock <= !last_i[grant_idx];
        if (!last_i[grant_idx]) begin
          lock_vc <= grant_idx;
        end
      end
      if (last_i[grant_idx] || !WormholeLock) begin
        rr_ptr <= (grant_idx == LastVc) ? '0 : grant_idx + VcW'(1);
      end
    end
  end

  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(ready_o));

  a_fire_has_credit : assert property (@(posedge clk_i) disable iff (rst_i)
    valid_o |-> (cnt[vc_id_o] != '0));

  for (genvar v = 0; v < NumVirtChannels; v++) begin : g_stable_chk
    a_input_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (valid_i[v] && !ready_o[v]) |=> (valid_i[v] && $stable(data_i[v])));
  end

endmodule

// File: tb/tb_floo_vc_credit_scheduler.sv
// Directed scoreboard bench for floo_vc_credit_scheduler with two VCs,
// credit depth two and wormhole locking enabled.
module tb_floo_vc_credit_scheduler;

  localparam int N = 2;
  localparam int D = 2;
  typedef logic [7:0] flit_t;
  typedef struct {
    int    vc;
    flit_t data;
  } xfer_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [N-1:0] valid_i;
  logic [N-1:0] ready_o;
  flit_t        data_i [N];
  logic [N-1:0] last_i;
  logic         valid_o;
  flit_t        data_o;
  logic [0:0]   vc_id_o;
  logic [N-1:0] credit_i;
  logic         credit_overflow_o;

  floo_vc_credit_scheduler #(
    .NumVirtChannels(N),
    .CreditDepth    (D),
    .WormholeLock   (1'b1),
    .flit_t         (flit_t)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .data_i           (data_i),
    .last_i           (last_i),
    .valid_o          (valid_o),
    .data_o           (data_o),
    .vc_id_o          (vc_id_o),
    .credit_i         (credit_i),
    .credit_overflow_o(credit_overflow_o)
  );

  always #5 clk_i = ~clk_i;

  xfer_t sb [$];
  int    checks   = 0;
  int    failures = 0;
  bit    exp_fire;
  int    exp_vc;
  bit    exp_ovf;
  flit_t d [N];

  task automatic compare(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, expv);
    end
  endtask

  // Drives one cycle of inputs and queues the transfer the link should carry.
  task automatic applyStimulus(input bit rst, input logic [1:0] v, input logic [1:0] l,
                               input logic [1:0] c, input bit fire, input int vc);
    @(negedge clk_i);
    rst_i     = rst;
    valid_i   = v;
    last_i    = l;
    credit_i  = c;
    data_i[0] = d[0];
    data_i[1] = d[1];
    exp_fire  = fire;
    exp_vc    = vc;
    if (rst) exp_ovf = 1'b0;
    if (fire) sb.push_back('{vc, d[vc]});
  endtask

  task automatic checkOutput(input string tag);
    xfer_t      e;
    logic [1:0] exp_ready;
    #1;
    exp_ready = exp_fire ? 2'(1 << exp_vc) : 2'b00;
    compare({tag, ".valid_o"}, 32'(valid_o), 32'(exp_fire));
    compare({tag, ".ready_o"}, 32'(ready_o), 32'(exp_ready));
    compare({tag, ".overflow"}, 32'(credit_overflow_o), 32'(exp_ovf));
    if (valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $error("[TB] FAIL %s.unexpected_xfer: observed=vc%0d expected=none", tag, vc_id_o);
      end else begin
        e = sb.pop_front();
        compare({tag, ".vc_id_o"}, 32'(vc_id_o), 32'(e.vc));
        compare({tag, ".data_o"}, 32'(data_o), 32'(e.data));
      end
    end else if (exp_fire && sb.size() > 0) begin
      void'(sb.pop_front());
    end
  endtask

  task automatic step(input string tag, input bit rst, input logic [1:0] v, input logic [1:0] l,
                      input logic [1:0] c, input bit fire, input int vc);
    applyStimulus(rst, v, l, c, fire, vc);
    checkOutput(tag);
    @(posedge clk_i);
    if (fire) d[vc] = d[vc] + 8'h1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i    = 1'b1;
    valid_i  = '0;
    last_i   = '0;
    credit_i = '0;
    d[0]     = 8'h10;
    d[1]     = 8'h80;
    data_i[0] = d[0];
    data_i[1] = d[1];
    exp_ovf  = 1'b0;

    // reset forces the link idle even with valid inputs
    step("rst0", 1'b1, 2'b11, 2'b11, 2'b00, 1'b0, 0);
    step("rst1", 1'b1, 2'b11, 2'b11, 2'b00, 1'b0, 0);

    // single-flit packets alternate 0,1,0,1 with same-cycle credit return
    step("alt0", 1'b0, 2'b11, 2'b11, 2'b01, 1'b1, 0);
    step("alt1", 1'b0, 2'b11, 2'b11, 2'b10, 1'b1, 1);
    step("alt2", 1'b0, 2'b11, 2'b11, 2'b01, 1'b1, 0);
    step("alt3", 1'b0, 2'b11, 2'b11, 2'b10, 1'b1, 1);

    // three-flit VC0 packet holds the link, then VC1 gets its turn
    step("pkt_h",   1'b0, 2'b11, 2'b10, 2'b01, 1'b1, 0);
    step("pkt_b",   1'b0, 2'b11, 2'b10, 2'b01, 1'b1, 0);
    step("pkt_t",   1'b0, 2'b11, 2'b11, 2'b01, 1'b1, 0);
    step("pkt_vc1", 1'b0, 2'b11, 2'b11, 2'b10, 1'b1, 1);

    // credit exhaustion: two fires, stall, one credit buys exactly one more
    step("dry0", 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 0);
    step("dry1", 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 0);
    step("dry2", 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 0);
    step("dry3", 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 0);
    step("cr",   1'b0, 2'b01, 2'b01, 2'b01, 1'b0, 0);
    step("one",  1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 0);
    step("none", 1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 0);

    // locked on VC0 with no credit: eligible VC1 is still blocked
    step("lk_cr",  1'b0, 2'b01, 2'b00, 2'b01, 1'b0, 0);
    step("lk_h",   1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 0);
    step("blk0",   1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 0);
    step("blk1",   1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 0);
    step("blk_cr", 1'b0, 2'b11, 2'b00, 2'b01, 1'b0, 0);
    step("lk_t",   1'b0, 2'b11, 2'b11, 2'b00, 1'b1, 0);
    step("vc1",    1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1);

    // fire plus credit on VC1 at cnt=1 keeps one credit: one more fire, then stall
    step("sim",  1'b0, 2'b10, 2'b10, 2'b10, 1'b1, 1);
    step("sim2", 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1);
    step("sim3", 1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 0);

    // refill VC0 to full, then an extra credit overflows and saturates
    step("r0a", 1'b0, 2'b10, 2'b10, 2'b01, 1'b0, 0);
    step("r0b", 1'b0, 2'b10, 2'b10, 2'b01, 1'b0, 0);
    step("ovf", 1'b0, 2'b10, 2'b10, 2'b01, 1'b0, 0);
    exp_ovf = 1'b1;
    step("ovf_a", 1'b0, 2'b11, 2'b11, 2'b00, 1'b1, 0);
    step("ovf_b", 1'b0, 2'b11, 2'b11, 2'b00, 1'b1, 0);
    step("ovf_c", 1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 0);

    // reset in the middle of a VC1 packet drops the lock and restores credits
    step("pre_cr",   1'b0, 2'b11, 2'b11, 2'b11, 1'b0, 0);
    step("pre_lk",   1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 1);
    step("mid_rst",  1'b1, 2'b11, 2'b11, 2'b00, 1'b0, 0);
    step("mid_rst2", 1'b1, 2'b11, 2'b11, 2'b00, 1'b0, 0);
    step("post0", 1'b0, 2'b11, 2'b11, 2'b00, 1'b1, 0);
    step("post1", 1'b0, 2'b11, 2'b11, 2'b00, 1'b1, 1);
    step("post2", 1'b0, 2'b11, 2'b11, 2'b00, 1'b1, 0);
    step("post3", 1'b0, 2'b11, 2'b11, 2'b00, 1'b1, 1);
    step("post4", 1'b0, 2'b11, 2'b11, 2'b00, 1'b0, 0);

    compare("sb_drain", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
